// File: rtl/reg_file_mp.sv
// Multi-port register file with per-register busy scoreboard for the MIPS datapath.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read forwarding).
module reg_file_mp #(
    parameter int NUM_REGISTERS = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_RD        = 2,
    parameter int ZERO_REG      = 1,
    localparam int ADDR_WIDTH   = $clog2(NUM_REGISTERS),
    localparam int CNT_WIDTH    = $clog2(NUM_REGISTERS + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic                         we0,
    input  logic [ADDR_WIDTH-1:0]        wa0,
    input  logic [DATA_WIDTH-1:0]        wd0,
    input  logic                         we1,
    input  logic [ADDR_WIDTH-1:0]        wa1,
    input  logic [DATA_WIDTH-1:0]        wd1,
    input  logic                         rsv_en,
    input  logic [ADDR_WIDTH-1:0]        rsv_addr,
    output logic [CNT_WIDTH-1:0]         busy_cnt
);

    // No handshake: every enable is a single-cycle strobe acted on at the edge
    // that samples it; there is no ready/backpressure path.

    logic [DATA_WIDTH-1:0]    regs_q [NUM_REGISTERS];
    logic [DATA_WIDTH-1:0]    regs_d [NUM_REGISTERS];
    logic [NUM_REGISTERS-1:0] busy_q;
    logic [NUM_REGISTERS-1:0] busy_d;
    logic [CNT_WIDTH-1:0]     busy_cnt_q;
    logic [CNT_WIDTH-1:0]     busy_cnt_d;

    function automatic logic is_zero_reg(input logic [ADDR_WIDTH-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Statement order encodes priority: port 1 over port 0, reservation over clear.
    always_comb begin
        regs_d     = regs_q;
        busy_d     = busy_q;
        busy_cnt_d = '0;
        if (we0 && !is_zero_reg(wa0)) begin
            regs_d[wa0] = wd0;
            busy_d[wa0] = 1'b0;
        end
        if (we1 && !is_zero_reg(wa1)) begin
            regs_d[wa1] = wd1;
            busy_d[wa1] = 1'b0;
        end
        if (rsv_en && !is_zero_reg(rsv_addr)) begin
            busy_d[rsv_addr] = 1'b1;
        end
        for (int r = 0; r < NUM_REGISTERS; r++) begin
            busy_cnt_d = busy_cnt_d + CNT_WIDTH'(busy_d[r]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q     <= '{default: '0};
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] data_i;
        logic                  busy_i;

        assign ra = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];

        // Register 0 under ZERO_REG is never written or reserved, so stored reads give 0.
        always_comb begin
            data_i = regs_q[ra];
            busy_i = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
            if (we1 && (wa1 == ra) && !is_zero_reg(ra)) begin
                data_i = wd1;
                busy_i = rsv_en && (rsv_addr == ra);
            end else if (we0 && (wa0 == ra) && !is_zero_reg(ra)) begin
                data_i = wd0;
                busy_i = rsv_en && (rsv_addr == ra);
            end
`endif
        end

        assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = data_i;
        assign rd_busy[i]                          = busy_i;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed vector table, corner sequences,
// and randomized traffic compared against a per-register reference model.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        we0, we1, rsv_en;
    logic [4:0]  wa0, wa1, rsv_addr;
    logic [31:0] wd0, wd1;
    logic [5:0]  busy_cnt;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] m_regs [32];
    logic        m_busy [32];

    reg_file_mp dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .we0      (we0),
        .wa0      (wa0),
        .wd0      (wd0),
        .we1      (we1),
        .wa1      (wa1),
        .wd1      (wd1),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .busy_cnt (busy_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        rsv;
        logic [4:0]  ra;
        logic [4:0]  r0;
        logic [4:0]  r1;
        logic [31:0] ed0;
        logic [31:0] ed1;
        logic        eb0;
        logic        eb1;
        logic [5:0]  ecnt;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        we0 = 1'b0; wa0 = '0; wd0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0;
        rsv_en = 1'b0; rsv_addr = '0;
    endtask

    function automatic logic [31:0] model_data(input logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
        if (a != 0 && we1 && wa1 == a) return wd1;
        if (a != 0 && we0 && wa0 == a) return wd0;
`endif
        return m_regs[a];
    endfunction

    function automatic logic model_busy(input logic [4:0] a);
`ifdef REGFILE_BYPASS_EN
        if (a != 0 && ((we1 && wa1 == a) || (we0 && wa0 == a)))
            return rsv_en && rsv_addr == a;
`endif
        return m_busy[a];
    endfunction

    function automatic int model_cnt();
        int n = 0;
        for (int r = 0; r < 32; r++) n += int'(m_busy[r]);
        return n;
    endfunction

    // Applies one edge of the cycle's inputs to the model, register by register.
    task automatic model_step();
        for (int r = 1; r < 32; r++) begin
            logic hit0, hit1, hitr;
            hit0 = we0 && wa0 == 5'(r);
            hit1 = we1 && wa1 == 5'(r);
            hitr = rsv_en && rsv_addr == 5'(r);
            if (hit1)      m_regs[r] = wd1;
            else if (hit0) m_regs[r] = wd0;
            if (hitr)              m_busy[r] = 1'b1;
            else if (hit0 || hit1) m_busy[r] = 1'b0;
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0,
                    5'd5, 5'd0, 32'h12345678, 32'h0, 1'b0, 1'b0, 6'd0};
        vecs[1] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7,
                    5'd7, 5'd5, 32'h0, 32'h12345678, 1'b1, 1'b0, 6'd1};
        vecs[2] = '{1'b1, 5'd7, 32'hA5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                    5'd7, 5'd7, 32'hA5, 32'hA5, 1'b0, 1'b0, 6'd0};
        vecs[3] = '{1'b1, 5'd9, 32'h11, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9,
                    5'd9, 5'd7, 32'h11, 32'hA5, 1'b1, 1'b0, 6'd1};
        vecs[4] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0,
                    5'd0, 5'd9, 32'h0, 32'h11, 1'b0, 1'b1, 6'd1};
        vecs[5] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3,
                    5'd3, 5'd9, 32'h0, 32'h11, 1'b1, 1'b1, 6'd2};
        vecs[6] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3,
                    5'd3, 5'd9, 32'h0, 32'h11, 1'b1, 1'b1, 6'd2};
        vecs[7] = '{1'b1, 5'd3, 32'h33, 1'b1, 5'd9, 32'h22, 1'b0, 5'd0,
                    5'd3, 5'd9, 32'h33, 32'h22, 1'b0, 1'b0, 6'd0};
        vecs[8] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd31,
                    5'd31, 5'd3, 32'h0, 32'h33, 1'b1, 1'b0, 6'd1};
        vecs[9] = '{1'b1, 5'd31, 32'h1, 1'b1, 5'd30, 32'h2, 1'b0, 5'd0,
                    5'd31, 5'd30, 32'h1, 32'h2, 1'b0, 1'b0, 6'd0};

        // Clock/reset
        idle();
        rd_addr = '0;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < 32; r++) begin
            @(negedge clk);
            rd_addr = {5'(31 - r), 5'(r)};
            #1;
            chk("rst_data0", rd_data[31:0], 32'h0);
            chk("rst_data1", rd_data[63:32], 32'h0);
            chk("rst_busy", 32'(rd_busy), 32'h0);
        end
        chk("rst_cnt", 32'(busy_cnt), 32'h0);

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            we0 = vecs[i].we0; wa0 = vecs[i].wa0; wd0 = vecs[i].wd0;
            we1 = vecs[i].we1; wa1 = vecs[i].wa1; wd1 = vecs[i].wd1;
            rsv_en = vecs[i].rsv; rsv_addr = vecs[i].ra;
            @(posedge clk);
            @(negedge clk);
            idle();
            rd_addr = {vecs[i].r1, vecs[i].r0};
            #1;
            chk($sformatf("vec%0d_data0", i), rd_data[31:0], vecs[i].ed0);
            chk($sformatf("vec%0d_data1", i), rd_data[63:32], vecs[i].ed1);
            chk($sformatf("vec%0d_busy0", i), 32'(rd_busy[0]), 32'(vecs[i].eb0));
            chk($sformatf("vec%0d_busy1", i), 32'(rd_busy[1]), 32'(vecs[i].eb1));
            chk($sformatf("vec%0d_cnt", i), 32'(busy_cnt), 32'(vecs[i].ecnt));
        end

        // Same-cycle read of a register being written
        @(negedge clk);
        rd_addr = {5'd0, 5'd12};
        we0 = 1'b1; wa0 = 5'd12; wd0 = 32'h55;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_same_cycle", rd_data[31:0], 32'h55);
`else
        chk("nobypass_same_cycle", rd_data[31:0], 32'h0);
`endif
        @(posedge clk);
        @(negedge clk);
        idle();
        #1;
        chk("write_next_cycle", rd_data[31:0], 32'h55);

        // Reset asserted mid-cycle discards that cycle's write and reservation
        @(negedge clk);
        rd_addr = {5'd5, 5'd20};
        we0 = 1'b1; wa0 = 5'd20; wd0 = 32'h77;
        rsv_en = 1'b1; rsv_addr = 5'd20;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_data", rd_data[63:32], 32'h0);
        chk("async_rst_cnt", 32'(busy_cnt), 32'h0);
        @(posedge clk);
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        #1;
        chk("rst_drop_data", rd_data[31:0], 32'h0);
        chk("rst_drop_busy", 32'(rd_busy), 32'h0);
        chk("rst_drop_cnt", 32'(busy_cnt), 32'h0);

        // Randomized traffic against the reference model
        for (int r = 0; r < 32; r++) begin
            m_regs[r] = '0;
            m_busy[r] = 1'b0;
        end
        for (int c = 0; c < 500; c++) begin
            logic [4:0] a;
            @(negedge clk);
            we0 = 1'($urandom_range(0, 1)); wa0 = 5'($urandom_range(0, 7)); wd0 = $urandom;
            we1 = 1'($urandom_range(0, 1)); wa1 = 5'($urandom_range(0, 7)); wd1 = $urandom;
            rsv_en = 1'($urandom_range(0, 1)); rsv_addr = 5'($urandom_range(0, 7));
            rd_addr = {5'($urandom_range(0, 8)), 5'($urandom_range(0, 8))};
            #1;
            for (int p = 0; p < 2; p++) begin
                a = rd_addr[p*5 +: 5];
                exp_q.push_back(model_data(a));
                exp_q.push_back(32'(model_busy(a)));
            end
            exp_q.push_back(32'(model_cnt()));
            chk("rnd_data0", rd_data[31:0], exp_q.pop_front());
            chk("rnd_busy0", 32'(rd_busy[0]), exp_q.pop_front());
            chk("rnd_data1", rd_data[63:32], exp_q.pop_front());
            chk("rnd_busy1", 32'(rd_busy[1]), exp_q.pop_front());
            chk("rnd_cnt", 32'(busy_cnt), exp_q.pop_front());
            @(posedge clk);
            model_step();
        end

        @(negedge clk);
        idle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
